// File: rtl/dtc.sv
`default_nettype none
// ============================================================================
// Module      : dtc
// Description : Digital-to-time converter. Takes a code over valid/ready,
//               drives an analog-reset hold interval, waits `code` cycles,
//               then emits a one-cycle comparator-style pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dtc #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 101
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] code,
    input  logic             valid,
    output logic             ready,
    input  logic             cont,
    output logic             ana_rst,
    output logic             cmp_o,
    output logic             busy,
    output logic [7:0]       n_pulses
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_HOLD = 2'd1;
    localparam logic [1:0]  S_RUN  = 2'd2;
    localparam logic [1:0]  S_FIRE = 2'd3;

    localparam logic [15:0] c_hold_last = 16'(HOLD - 1);

    logic [1:0]       r_state;
    logic [15:0]      r_hold_cnt;
    logic [WIDTH-1:0] r_run_cnt;
    logic [WIDTH-1:0] r_code;
    logic             r_ana_rst;
    logic             r_cmp;
    logic             r_busy;
    logic [7:0]       r_n_pulses;

    logic [1:0]       w_state_d;
    logic [15:0]      w_hold_cnt_d;
    logic [WIDTH-1:0] w_run_cnt_d;
    logic [WIDTH-1:0] w_code_d;
    logic             w_ana_rst_d;
    logic             w_cmp_d;
    logic             w_busy_d;
    logic [7:0]       w_n_pulses_d;
    logic             w_xfer;

    // ready is the only combinational output; it must drop while rst is high
    assign ready  = ((r_state == S_IDLE) || (r_state == S_FIRE)) && !rst;
    assign w_xfer = valid && ready;

    always_comb begin
        w_state_d    = r_state;
        w_hold_cnt_d = r_hold_cnt;
        w_run_cnt_d  = r_run_cnt;
        w_code_d     = r_code;
        w_ana_rst_d  = r_ana_rst;
        w_cmp_d      = 1'b0;
        w_n_pulses_d = r_n_pulses;

        case (r_state)
            S_IDLE: begin
                w_ana_rst_d = 1'b0;
                if (w_xfer) begin
                    w_code_d     = code;
                    w_state_d    = S_HOLD;
                    w_ana_rst_d  = 1'b1;
                    w_hold_cnt_d = 16'd0;
                end
            end
            S_HOLD: begin
                w_hold_cnt_d = r_hold_cnt + 16'd1;
                if (r_hold_cnt == c_hold_last) begin
                    w_ana_rst_d = 1'b0;
                    w_run_cnt_d = '0;
                    if (r_code == '0) begin
                        w_state_d    = S_FIRE;
                        w_cmp_d      = 1'b1;
                        w_n_pulses_d = r_n_pulses + 8'd1;
                    end else begin
                        w_state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                w_run_cnt_d = r_run_cnt + WIDTH'(1);
                // r_code is nonzero here, so code-1 cannot underflow
                if (r_run_cnt == (r_code - WIDTH'(1))) begin
                    w_state_d    = S_FIRE;
                    w_cmp_d      = 1'b1;
                    w_n_pulses_d = r_n_pulses + 8'd1;
                end
            end
            S_FIRE: begin
                if (w_xfer) begin
                    w_code_d     = code;
                    w_state_d    = S_HOLD;
                    w_ana_rst_d  = 1'b1;
                    w_hold_cnt_d = 16'd0;
                end else if (cont) begin
                    w_state_d    = S_HOLD;
                    w_ana_rst_d  = 1'b1;
                    w_hold_cnt_d = 16'd0;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= 16'd0;
            r_run_cnt  <= '0;
            r_code     <= '0;
            r_ana_rst  <= 1'b0;
            r_cmp      <= 1'b0;
            r_busy     <= 1'b0;
            r_n_pulses <= 8'd0;
        end else begin
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_cnt_d;
            r_run_cnt  <= w_run_cnt_d;
            r_code     <= w_code_d;
            r_ana_rst  <= w_ana_rst_d;
            r_cmp      <= w_cmp_d;
            r_busy     <= w_busy_d;
            r_n_pulses <= w_n_pulses_d;
        end
    end

    assign ana_rst  = r_ana_rst;
    assign cmp_o    = r_cmp;
    assign busy     = r_busy;
    assign n_pulses = r_n_pulses;

endmodule
`default_nettype wire

// File: tb/tb_dtc.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtc
// Description : Self-checking bench for dtc with an expected-interval queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtc;

    localparam int WIDTH = 8;
    localparam int HOLD  = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] code = '0;
    logic             valid = 1'b0;
    logic             ready;
    logic             cont = 1'b0;
    logic             ana_rst;
    logic             cmp_o;
    logic             busy;
    logic [7:0]       n_pulses;

    int   total = 0;
    int   bad   = 0;
    int   exp_q[$];
    logic [7:0] exp_np = 8'd0;
    int   hi_len = 0;
    int   lo_len = 0;
    logic prev_ana = 1'b0;

    dtc #(.WIDTH(WIDTH), .HOLD(HOLD)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .code     (code),
        .valid    (valid),
        .ready    (ready),
        .cont     (cont),
        .ana_rst  (ana_rst),
        .cmp_o    (cmp_o),
        .busy     (busy),
        .n_pulses (n_pulses)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: measure the analog-reset and run intervals, pop on each pulse
    always @(negedge clk) begin
        if (rst) begin
            hi_len = 0;
            lo_len = 0;
        end else if (ana_rst) begin
            hi_len = prev_ana ? hi_len + 1 : 1;
            lo_len = 0;
        end else if (cmp_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                chk("gap", lo_len, exp_q.pop_front());
                exp_np = exp_np + 8'd1;
                chk("hold_len", hi_len, HOLD);
                chk("n_pulses", n_pulses, exp_np);
            end
        end else if (busy) begin
            lo_len++;
        end
        prev_ana = ana_rst;
    end

    task automatic send(input logic [WIDTH-1:0] c);
        int n;
        n     = 0;
        code  = c;
        valid = 1'b1;
        while (!ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("send_timeout", n, 0);
        exp_q.push_back(int'(c));
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || exp_q.size() != 0) && n < 1000);
        if (n >= 1000) chk({tag, "_timeout"}, n, 0);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        exp_np = 8'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Continuous mode: count pulses and check the period, stop after n pulses
    task automatic run_cont(input logic [WIDTH-1:0] c, input int n_pulse, input int period);
        int pulses;
        int last;
        int t;
        pulses = 0;
        last   = 0;
        t      = 0;
        for (int i = 0; i < n_pulse - 1; i++) exp_q.push_back(int'(c));
        cont = 1'b1;
        send(c);
        while (pulses < n_pulse && t < 5000) begin
            @(negedge clk);
            t++;
            if (cmp_o) begin
                if (pulses > 0) chk("period", t - last, period);
                last = t;
                pulses++;
                if (pulses == n_pulse) cont = 1'b0;
            end
        end
        if (pulses < n_pulse) chk("cont_timeout", pulses, n_pulse);
        cont = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_ana", ana_rst, 0);
        chk("rst_cmp", cmp_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_np", n_pulses, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", ready, 1);

        // single transfers, including boundary codes
        send(8'd5);
        chk("busy_after_xfer", busy, 1);
        chk("ana_after_xfer", ana_rst, 1);
        wait_done("code5");
        chk("np_after_code5", n_pulses, 1);
        send(8'd0);
        wait_done("code0");
        send(8'd255);
        wait_done("code255");
        chk("np_after_3", n_pulses, 3);

        // continuous mode wraps the pulse counter
        do_reset();
        run_cont(8'd3, 256, HOLD + 3 + 1);
        @(negedge clk);
        chk("np_wrap", n_pulses, 0);
        chk("cont_stop_busy", busy, 0);

        // valid held high: second code accepted in FIRE of the first
        code  = 8'd2;
        valid = 1'b1;
        exp_q.push_back(2);
        @(posedge clk);
        #1;
        code = 8'd7;
        exp_q.push_back(7);
        for (int i = 0; i < HOLD + 2; i++) begin
            @(negedge clk);
            chk("ready_low_busy", ready, 0);
        end
        @(negedge clk);
        chk("fire_cmp", cmp_o, 1);
        chk("fire_ready", ready, 1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        @(negedge clk);
        chk("b2b_no_idle", ana_rst, 1);
        wait_done("b2b");

        // loopback-style interval check in continuous mode
        run_cont(8'd20, 3, HOLD + 20 + 1);
        wait_done("loop");

        // reset mid-RUN aborts the pulse
        do_reset();
        send(8'd10);
        repeat (HOLD + 4) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_np = 8'd0;
        @(negedge clk);
        chk("abort_ana", ana_rst, 0);
        chk("abort_cmp", cmp_o, 0);
        chk("abort_busy", busy, 0);
        chk("abort_np", n_pulses, 0);
        chk("abort_ready_rst", ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (cmp_o) seen++;
            end
            chk("abort_no_pulse", seen, 0);
        end
        chk("abort_np_final", n_pulses, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dtc.md
# dtc

Digital-to-time converter: the transmit-side counterpart of the comparator-interval counter. It accepts an 8-bit code over a valid/ready handshake and reproduces the analog event sequence that the counter measures. First it drives an analog-reset interval, then it waits exactly `code` cycles, then it emits a one-cycle comparator-style pulse. It sits in the digital top level as a calibration/loopback stimulus source. Its `cmp_o` output can be routed to the counter's comparator input in place of the analog comparator.

## Interface
- `WIDTH`, 8: code width and run-counter width.
- `HOLD`, 101: analog-reset hold length in cycles; legal range 1..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `code`  in  WIDTH  interval code; sampled on handshake.
- `valid`  in  1  code offered.
- `ready`  out  1  block can accept a code this cycle.
- `cont`  in  1  continuous mode; sampled in FIRE.
- `ana_rst`  out  1  analog reset request (registered).
- `cmp_o`  out  1  one-cycle comparator-style pulse (registered).
- `busy`  out  1  high in HOLD, RUN, FIRE (registered).
- `n_pulses`  out  8  count of `cmp_o` pulses since reset; wraps 255->0.

## Operation
- States: IDLE, HOLD, RUN, FIRE.
- Transfer occurs on any rising edge where `valid && ready`. The code is latched into `code_q`.
- `ready` = (state==IDLE || state==FIRE) && !rst. It is combinational from state and is the only combinational output.
- IDLE: on transfer go to HOLD, set `ana_rst`=1, clear the hold counter. Otherwise stay, with `ana_rst`=0.
- HOLD:
  - The hold counter increments each cycle.
  - When the counter reaches HOLD-1, go to RUN, clear the run counter, and drop `ana_rst`.
  - If `code_q`==0, go straight to FIRE instead of RUN.
- RUN:
  - The run counter increments each cycle.
  - When it reaches `code_q`-1, go to FIRE and set `cmp_o`=1.
  - The run counter is WIDTH bits. `code_q`=255 gives 255 RUN cycles; there is no overflow.
- FIRE: `cmp_o` is high for this single cycle, and `n_pulses` increments on entry. Exit priority:
  1. Transfer (`valid`): latch the new code, go to HOLD, set `ana_rst`=1.
  2. Else `cont`=1: reuse `code_q`, go to HOLD, set `ana_rst`=1.
  3. Else go to IDLE.
- `valid` outside IDLE/FIRE is ignored (no transfer, since `ready`=0). A code offered during HOLD or RUN is not lost only if the source holds `valid` until `ready`.
- `code` is don't-care when no transfer occurs.
- Reset:
  - State goes to IDLE.
  - `ana_rst`=0, `cmp_o`=0, `busy`=0, `n_pulses`=0, `code_q`=0, and all counters are 0.
  - `ready`=0 while `rst` is high and goes to 1 the cycle after `rst` falls.
  - Reset mid-HOLD, RUN, or FIRE aborts immediately: no `cmp_o`, and `n_pulses` keeps no partial count.

## Timing
- Transfer at edge N gives:
  - `ana_rst` high from N through N+HOLD (low after edge N+HOLD).
  - `cmp_o` high for exactly one cycle after edge N+HOLD+`code`.
- Interval from `ana_rst` fall to `cmp_o` rise = `code` cycles. Code 0 gives `cmp_o` in the cycle directly after `ana_rst` falls.
- Back-to-back via FIRE transfer or `cont`: `ana_rst` rises on the edge ending the FIRE cycle. Period = HOLD+`code`+1 cycles.
- `busy` mirrors state with no lag: it is high in any cycle where the state is HOLD, RUN or FIRE.
- `n_pulses` updates on the same edge that raises `cmp_o`.

## Test plan
- HOLD=4, `rst` for 2 cycles, then `code`=5 with `valid` for 1 cycle → `ana_rst` high 4 cycles, low 5 cycles, `cmp_o` high 1 cycle, `n_pulses`=1, `ready` back high, `busy` low.
- `code`=0 → `cmp_o` in the first cycle after `ana_rst` falls. `code`=255 → exactly 255 low cycles between `ana_rst` fall and `cmp_o`.
- `cont`=1, single transfer of `code`=3, HOLD=4 → `cmp_o` every 8 cycles. After 256 pulses `n_pulses` reads 0.
- `valid` held high with codes 2 then 7 → second transfer occurs in the FIRE cycle of the first. Gaps are 2 then 7 with no IDLE cycle between. `valid` during HOLD/RUN sees `ready`=0.
- `rst` pulsed mid-RUN (`code`=10, 4 cycles into RUN) → no `cmp_o`, all outputs 0 the next cycle, `ready`=1 one cycle after `rst` falls, `n_pulses` unchanged from 0.
- Loopback: `cmp_o` driving the counter's comparator input, with `code`=20 in `cont` mode → successive counter readings are consistent with the programmed interval.
